// File: rtl/alu_pipe_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_unit_if
// Description : Issue (reservation station) and result (CDB) handshake bundle
//               for alu_pipe_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_pipe_unit_if #(
    parameter int WIDTH = 64,
    parameter int TAG_W = 5
);
    logic               in_valid;
    logic               out_ready;
    logic [TAG_W-1:0]   in_tag;
    logic [3:0]         in_alu_op;
    logic [WIDTH-1:0]   in_val_a;
    logic [WIDTH-1:0]   in_val_b;
    logic [5:0]         in_alu_val_hw;
    logic [5:0]         in_immr;
    logic [5:0]         in_imms;
    logic               in_set_CC;
    logic [3:0]         in_cond;
    logic [3:0]         in_prev_nzcv;
    logic               in_flush;
    logic               out_valid;
    logic               in_ready;
    logic [TAG_W-1:0]   out_tag;
    logic [WIDTH-1:0]   out_value;
    logic [3:0]         out_nzcv;
    logic               out_cond_val;

    modport master (
        output in_valid, in_tag, in_alu_op, in_val_a, in_val_b, in_alu_val_hw,
               in_immr, in_imms, in_set_CC, in_cond, in_prev_nzcv, in_flush, in_ready,
        input  out_ready, out_valid, out_tag, out_value, out_nzcv, out_cond_val
    );

    modport slave (
        input  in_valid, in_tag, in_alu_op, in_val_a, in_val_b, in_alu_val_hw,
               in_immr, in_imms, in_set_CC, in_cond, in_prev_nzcv, in_flush, in_ready,
        output out_ready, out_valid, out_tag, out_value, out_nzcv, out_cond_val
    );
endinterface
`default_nettype wire

// File: rtl/alu_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_pipe_unit
// Description : Pipelined ALU/bitfield execute unit with NZCV, back-pressure,
//               bubble collapsing and flush.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_pipe_unit #(
    parameter int WIDTH  = 64,
    parameter int TAG_W  = 5,
    parameter int STAGES = 2
) (
    input wire logic        in_clk,
    input wire logic        in_rst,
    alu_pipe_unit_if.slave  bus
);
    localparam logic [3:0] c_OP_PLUS  = 4'd0,  c_OP_MINUS = 4'd1,  c_OP_ORN   = 4'd2;
    localparam logic [3:0] c_OP_OR    = 4'd3,  c_OP_EOR   = 4'd4,  c_OP_AND   = 4'd5;
    localparam logic [3:0] c_OP_MOV   = 4'd6,  c_OP_CSEL  = 4'd7,  c_OP_CSINC = 4'd8;
    localparam logic [3:0] c_OP_CSINV = 4'd9,  c_OP_CSNEG = 4'd10, c_OP_PASSA = 4'd11;
    localparam logic [3:0] c_OP_UBFM  = 4'd12, c_OP_SBFM  = 4'd13;

    localparam logic [7:0]     c_W8   = 8'(WIDTH);
    localparam logic [WIDTH:0] c_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH-1:0] c_ONEW = WIDTH'(1);

    function automatic logic [WIDTH-1:0] f_mask(input logic [7:0] n);
        logic [WIDTH:0] t;
        t = (c_ONE << n) - c_ONE;
        return (n >= c_W8) ? '1 : t[WIDTH-1:0];
    endfunction

    logic [WIDTH-1:0] w_a, w_b, w_res, w_ubfm, w_sbfm;
    logic [WIDTH:0]   w_sum, w_diff;
    logic [7:0]       w_r, w_s, w_top, w_hw;
    logic             w_n, w_z, w_c, w_v, w_cond_base, w_cond, w_carry, w_ovf, w_sign;
    logic [3:0]       w_nzcv;

    always_comb begin
        w_a    = bus.in_val_a;
        w_b    = bus.in_val_b;
        w_sum  = {1'b0, w_a} + {1'b0, w_b};
        w_diff = {1'b0, w_a} + {1'b0, ~w_b} + c_ONE;
        w_hw   = {2'b00, bus.in_alu_val_hw} & (c_W8 - 8'd1);

        {w_n, w_z, w_c, w_v} = bus.in_prev_nzcv;
        case (bus.in_cond[3:1])
            3'd0:    w_cond_base = w_z;
            3'd1:    w_cond_base = w_c;
            3'd2:    w_cond_base = w_n;
            3'd3:    w_cond_base = w_v;
            3'd4:    w_cond_base = w_c & ~w_z;
            3'd5:    w_cond_base = (w_n == w_v);
            3'd6:    w_cond_base = (w_n == w_v) & ~w_z;
            default: w_cond_base = 1'b1;
        endcase
        // Odd encodings invert the base test, except NV which behaves like AL.
        w_cond = (bus.in_cond[0] && bus.in_cond[3:1] != 3'd7) ? ~w_cond_base : w_cond_base;

        w_r = {2'b00, bus.in_immr};
        w_s = {2'b00, bus.in_imms};
        if (w_s >= w_r) begin
            w_ubfm = (w_a >> w_r) & f_mask(w_s - w_r + 8'd1);
            w_top  = w_s - w_r;
        end else begin
            w_ubfm = (w_a & f_mask(w_s + 8'd1)) << (c_W8 - w_r);
            w_top  = c_W8 - w_r + w_s;
        end
        w_sign = |(w_ubfm & (c_ONEW << w_top));
        w_sbfm = w_sign ? (w_ubfm | ~f_mask(w_top + 8'd1)) : w_ubfm;

        case (bus.in_alu_op)
            c_OP_PLUS:  w_res = w_sum[WIDTH-1:0];
            c_OP_MINUS: w_res = w_diff[WIDTH-1:0];
            c_OP_ORN:   w_res = w_a | ~w_b;
            c_OP_OR:    w_res = w_a | w_b;
            c_OP_EOR:   w_res = w_a ^ w_b;
            c_OP_AND:   w_res = w_a & w_b;
            c_OP_MOV:   w_res = w_a | (w_b << w_hw);
            c_OP_CSEL:  w_res = w_cond ? w_a : w_b;
            c_OP_CSINC: w_res = w_cond ? w_a : w_b + c_ONEW;
            c_OP_CSINV: w_res = w_cond ? w_a : ~w_b;
            c_OP_CSNEG: w_res = w_cond ? w_a : -w_b;
            c_OP_PASSA: w_res = w_a;
            c_OP_UBFM:  w_res = w_ubfm;
            c_OP_SBFM:  w_res = w_sbfm;
            default:    w_res = '0;
        endcase

        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (bus.in_alu_op == c_OP_PLUS) begin
            w_carry = w_sum[WIDTH];
            w_ovf   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
        end else if (bus.in_alu_op == c_OP_MINUS) begin
            w_carry = w_diff[WIDTH];
            w_ovf   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
        end
        w_nzcv = bus.in_set_CC ? {w_res[WIDTH-1], (w_res == '0), w_carry, w_ovf}
                               : bus.in_prev_nzcv;
    end

    logic [STAGES:1]  r_vld;
    logic [TAG_W-1:0] r_tag  [1:STAGES];
    logic [WIDTH-1:0] r_val  [1:STAGES];
    logic [3:0]       r_nzcv [1:STAGES];
    logic [STAGES:1]  r_cv;

    logic [STAGES:1]  w_adv, w_load, w_src_vld, w_src_cv;
    logic [TAG_W-1:0] w_src_tag  [1:STAGES];
    logic [WIDTH-1:0] w_src_val  [1:STAGES];
    logic [3:0]       w_src_nzcv [1:STAGES];
    logic             w_room;

    // Walk from the sink backwards so an empty slot anywhere lets everything upstream move.
    always_comb begin
        w_adv  = '0;
        w_load = '0;
        w_room = bus.in_ready;
        for (int k = STAGES; k >= 1; k--) begin
            w_adv[k]  = r_vld[k] & w_room;
            w_load[k] = ~r_vld[k] | w_adv[k];
            w_room    = w_load[k];
        end
    end

    always_comb begin
        w_src_vld[1]  = bus.in_valid;
        w_src_tag[1]  = bus.in_tag;
        w_src_val[1]  = w_res;
        w_src_nzcv[1] = w_nzcv;
        w_src_cv[1]   = w_cond;
        for (int k = 2; k <= STAGES; k++) begin
            w_src_vld[k]  = r_vld[k-1];
            w_src_tag[k]  = r_tag[k-1];
            w_src_val[k]  = r_val[k-1];
            w_src_nzcv[k] = r_nzcv[k-1];
            w_src_cv[k]   = r_cv[k-1];
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_vld <= '0;
            r_cv  <= '0;
            for (int k = 1; k <= STAGES; k++) begin
                r_tag[k]  <= '0;
                r_val[k]  <= '0;
                r_nzcv[k] <= '0;
            end
        end else begin
            for (int k = 1; k <= STAGES; k++) begin
                if (w_load[k]) begin
                    r_vld[k]  <= w_src_vld[k];
                    r_tag[k]  <= w_src_tag[k];
                    r_val[k]  <= w_src_val[k];
                    r_nzcv[k] <= w_src_nzcv[k];
                    r_cv[k]   <= w_src_cv[k];
                end
            end
            if (bus.in_flush) begin
                r_vld <= '0;
            end
        end
    end

    assign bus.out_ready    = w_load[1];
    assign bus.out_valid    = r_vld[STAGES];
    assign bus.out_tag      = r_tag[STAGES];
    assign bus.out_value    = r_val[STAGES];
    assign bus.out_nzcv     = r_nzcv[STAGES];
    assign bus.out_cond_val = r_cv[STAGES];
endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_pipe_unit
// Description : Directed self-checking bench for alu_pipe_unit (64b/2-stage and 32b/1-stage).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_pipe_unit;
    localparam logic [3:0] OP_PLUS = 4'd0, OP_MINUS = 4'd1, OP_MOV = 4'd6, OP_CSINC = 4'd8;
    localparam logic [3:0] OP_CSNEG = 4'd10, OP_PASS_A = 4'd11, OP_UBFM = 4'd12, OP_SBFM = 4'd13;
    localparam logic [3:0] C_EQ = 4'd0, C_GT = 4'd12, C_AL = 4'd14;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    alu_pipe_unit_if #(.WIDTH(64), .TAG_W(5)) b64();
    alu_pipe_unit_if #(.WIDTH(32), .TAG_W(5)) b32();

    alu_pipe_unit #(.WIDTH(64), .TAG_W(5), .STAGES(2)) dut64 (.in_clk(clk), .in_rst(rst), .bus(b64));
    alu_pipe_unit #(.WIDTH(32), .TAG_W(5), .STAGES(1)) dut32 (.in_clk(clk), .in_rst(rst), .bus(b32));

    always #5 clk = ~clk;

    task automatic drive64(input logic [4:0] tag, input logic [3:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [3:0] cond, input logic [3:0] prev,
                           input logic setcc, input logic [5:0] hw, input logic [5:0] immr,
                           input logic [5:0] imms);
        b64.in_valid = 1'b1;   b64.in_tag = tag;       b64.in_alu_op = op;
        b64.in_val_a = a;      b64.in_val_b = b;       b64.in_cond = cond;
        b64.in_prev_nzcv = prev; b64.in_set_CC = setcc; b64.in_alu_val_hw = hw;
        b64.in_immr = immr;    b64.in_imms = imms;
    endtask

    task automatic drive32(input logic [4:0] tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic setcc, input logic [5:0] hw);
        b32.in_valid = 1'b1;   b32.in_tag = tag;       b32.in_alu_op = op;
        b32.in_val_a = a;      b32.in_val_b = b;       b32.in_cond = C_AL;
        b32.in_prev_nzcv = 4'b0000; b32.in_set_CC = setcc; b32.in_alu_val_hw = hw;
        b32.in_immr = 6'd0;    b32.in_imms = 6'd0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b64.in_valid = 1'b0; b64.in_flush = 1'b0; b64.in_ready = 1'b1;
        b32.in_valid = 1'b0; b32.in_flush = 1'b0; b32.in_ready = 1'b1;
        drive64(0, OP_PLUS, 0, 0, C_AL, 0, 0, 0, 0, 0); b64.in_valid = 1'b0;
        drive32(0, OP_PLUS, 0, 0, 0, 0);                b32.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (b64.out_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", b64.out_valid); else n_pass++;
        n_checks++; if (b64.out_tag !== 5'd0) $display("FAIL rst_tag got %0d want 0", b64.out_tag); else n_pass++;
        n_checks++; if (b64.out_value !== 64'd0) $display("FAIL rst_value got %h want 0", b64.out_value); else n_pass++;
        n_checks++; if ({b64.out_nzcv, b64.out_cond_val} !== 5'd0) $display("FAIL rst_flags got %b want 00000", {b64.out_nzcv, b64.out_cond_val}); else n_pass++;
        n_checks++; if (b64.out_ready !== 1'b1) $display("FAIL rst_ready got %b want 1", b64.out_ready); else n_pass++;
        n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL rst_valid32 got %b want 0", b32.out_valid); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_plus();
        drive64(5'd3, OP_PLUS, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, C_AL, 4'b0000, 1'b1, 0, 0, 0);
        @(negedge clk); b64.in_valid = 1'b0;
        n_checks++; if (b64.out_valid !== 1'b0) $display("FAIL plus_early got %b want 0", b64.out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_valid !== 1'b1) $display("FAIL plus_valid got %b want 1", b64.out_valid); else n_pass++;
        n_checks++; if (b64.out_tag !== 5'd3) $display("FAIL plus_tag got %0d want 3", b64.out_tag); else n_pass++;
        n_checks++; if (b64.out_value !== 64'd0) $display("FAIL plus_value got %h want 0", b64.out_value); else n_pass++;
        n_checks++; if (b64.out_nzcv !== 4'b0110) $display("FAIL plus_nzcv got %b want 0110", b64.out_nzcv); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_valid !== 1'b0) $display("FAIL plus_retire got %b want 0", b64.out_valid); else n_pass++;
    endtask

    task automatic test_minus();
        drive64(5'd4, OP_MINUS, 64'h8000_0000_0000_0000, 64'd1, C_AL, 4'b0000, 1'b1, 0, 0, 0);
        @(negedge clk);
        drive64(5'd5, OP_MINUS, 64'h8000_0000_0000_0000, 64'd1, C_AL, 4'b1000, 1'b0, 0, 0, 0);
        @(negedge clk); b64.in_valid = 1'b0;
        n_checks++; if (b64.out_tag !== 5'd4 || b64.out_valid !== 1'b1) $display("FAIL minus_tag got %0d/%b want 4/1", b64.out_tag, b64.out_valid); else n_pass++;
        n_checks++; if (b64.out_value !== 64'h7FFF_FFFF_FFFF_FFFF) $display("FAIL minus_value got %h want 7fffffffffffffff", b64.out_value); else n_pass++;
        n_checks++; if (b64.out_nzcv !== 4'b0011) $display("FAIL minus_nzcv got %b want 0011", b64.out_nzcv); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_tag !== 5'd5 || b64.out_valid !== 1'b1) $display("FAIL minus_nocc_tag got %0d/%b want 5/1", b64.out_tag, b64.out_valid); else n_pass++;
        n_checks++; if (b64.out_nzcv !== 4'b1000) $display("FAIL minus_nocc_nzcv got %b want 1000", b64.out_nzcv); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        drive64(5'd6, OP_CSINC, 64'd5, 64'd9, C_EQ, 4'b1001, 1'b1, 0, 0, 0);
        @(negedge clk);
        drive64(5'd7, OP_UBFM, 64'hF0, 64'd0, C_AL, 4'b0000, 1'b0, 0, 6'd4, 6'd7);
        @(negedge clk);
        drive64(5'd8, OP_SBFM, 64'h80, 64'd0, C_AL, 4'b0110, 1'b1, 0, 6'd0, 6'd7);
        n_checks++; if (b64.out_tag !== 5'd6 || b64.out_value !== 64'd10) $display("FAIL csinc got tag %0d val %h want 6/a", b64.out_tag, b64.out_value); else n_pass++;
        n_checks++; if ({b64.out_nzcv, b64.out_cond_val} !== 5'b00000) $display("FAIL csinc_flags got %b want 00000", {b64.out_nzcv, b64.out_cond_val}); else n_pass++;
        @(negedge clk);
        drive64(5'd9, OP_CSNEG, 64'd5, 64'd3, C_GT, 4'b0100, 1'b0, 0, 0, 0);
        n_checks++; if (b64.out_tag !== 5'd7 || b64.out_value !== 64'hF) $display("FAIL ubfm got tag %0d val %h want 7/f", b64.out_tag, b64.out_value); else n_pass++;
        @(negedge clk); b64.in_valid = 1'b0;
        n_checks++; if (b64.out_tag !== 5'd8 || b64.out_value !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL sbfm got tag %0d val %h want 8/ffffffffffffff80", b64.out_tag, b64.out_value); else n_pass++;
        n_checks++; if (b64.out_nzcv !== 4'b1000) $display("FAIL sbfm_nzcv got %b want 1000", b64.out_nzcv); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_value !== 64'hFFFF_FFFF_FFFF_FFFD || b64.out_cond_val !== 1'b0) $display("FAIL csneg got %h/%b want fffffffffffffffd/0", b64.out_value, b64.out_cond_val); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_stall();
        b64.in_ready = 1'b0;
        drive64(5'd10, OP_PASS_A, 64'd100, 64'd0, C_AL, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (b64.out_ready !== 1'b1) $display("FAIL stall_rdy0 got %b want 1", b64.out_ready); else n_pass++;
        @(negedge clk);
        drive64(5'd11, OP_PASS_A, 64'd101, 64'd0, C_AL, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (b64.out_ready !== 1'b1 || b64.out_valid !== 1'b0) $display("FAIL stall_rdy1 got %b/%b want 1/0", b64.out_ready, b64.out_valid); else n_pass++;
        @(negedge clk);
        drive64(5'd12, OP_PASS_A, 64'd102, 64'd0, C_AL, 0, 0, 0, 0, 0);
        #1;
        n_checks++; if (b64.out_ready !== 1'b0) $display("FAIL stall_full_rdy got %b want 0", b64.out_ready); else n_pass++;
        n_checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 5'd10) $display("FAIL stall_head got %b/%0d want 1/10", b64.out_valid, b64.out_tag); else n_pass++;
        @(negedge clk);
        b64.in_ready = 1'b1;
        #1;
        n_checks++; if (b64.out_ready !== 1'b1 || b64.out_tag !== 5'd10) $display("FAIL stall_release got %b/%0d want 1/10", b64.out_ready, b64.out_tag); else n_pass++;
        @(negedge clk); b64.in_valid = 1'b0;
        n_checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 5'd11 || b64.out_value !== 64'd101) $display("FAIL stall_op2 got %b/%0d/%0d want 1/11/101", b64.out_valid, b64.out_tag, b64.out_value); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 5'd12 || b64.out_value !== 64'd102) $display("FAIL stall_op3 got %b/%0d/%0d want 1/12/102", b64.out_valid, b64.out_tag, b64.out_value); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_valid !== 1'b0) $display("FAIL stall_dup got %b want 0", b64.out_valid); else n_pass++;
    endtask

    task automatic test_flush();
        drive64(5'd20, OP_PASS_A, 64'd200, 64'd0, C_AL, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive64(5'd21, OP_PASS_A, 64'd201, 64'd0, C_AL, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive64(5'd22, OP_PASS_A, 64'd202, 64'd0, C_AL, 0, 0, 0, 0, 0);
        b64.in_flush = 1'b1;
        #1;
        n_checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 5'd20) $display("FAIL flush_pre got %b/%0d want 1/20", b64.out_valid, b64.out_tag); else n_pass++;
        @(negedge clk);
        b64.in_flush = 1'b0; b64.in_valid = 1'b0;
        #1;
        n_checks++; if (b64.out_valid !== 1'b0 || b64.out_ready !== 1'b1) $display("FAIL flush_clear got %b/%b want 0/1", b64.out_valid, b64.out_ready); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_valid !== 1'b0) $display("FAIL flush_late got %b want 0", b64.out_valid); else n_pass++;
        drive64(5'd23, OP_PASS_A, 64'd203, 64'd0, C_AL, 0, 0, 0, 0, 0);
        @(negedge clk); b64.in_valid = 1'b0;
        n_checks++; if (b64.out_valid !== 1'b0) $display("FAIL flush_next_early got %b want 0", b64.out_valid); else n_pass++;
        @(negedge clk);
        n_checks++; if (b64.out_valid !== 1'b1 || b64.out_tag !== 5'd23 || b64.out_value !== 64'd203) $display("FAIL flush_next got %b/%0d/%0d want 1/23/203", b64.out_valid, b64.out_tag, b64.out_value); else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_width32();
        drive32(5'd9, OP_PLUS, 32'hFFFF_FFFF, 32'd1, 1'b1, 6'd0);
        n_checks++; if (b32.out_valid !== 1'b0) $display("FAIL w32_idle got %b want 0", b32.out_valid); else n_pass++;
        @(negedge clk);
        drive32(5'd10, OP_MOV, 32'd1, 32'd1, 1'b0, 6'd36);
        n_checks++; if (b32.out_valid !== 1'b1 || b32.out_tag !== 5'd9 || b32.out_value !== 32'd0) $display("FAIL w32_plus got %b/%0d/%h want 1/9/0", b32.out_valid, b32.out_tag, b32.out_value); else n_pass++;
        n_checks++; if (b32.out_nzcv !== 4'b0110) $display("FAIL w32_nzcv got %b want 0110", b32.out_nzcv); else n_pass++;
        @(negedge clk); b32.in_valid = 1'b0;
        n_checks++; if (b32.out_tag !== 5'd10 || b32.out_value !== 32'h11) $display("FAIL w32_mov got %0d/%h want 10/11", b32.out_tag, b32.out_value); else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_plus();
        test_minus();
        test_back_to_back();
        test_stall();
        test_flush();
        test_width32();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
